// File: rtl/sdram_arbit.sv
// sdram_arbit: SDRAM command-bus arbiter (init hold, then AREF > WRITE > READ) with pin mux and grant watchdog.
module sdram_arbit #(
  parameter logic [9:0] GRANT_TMO = 10'd1023,
  parameter logic [3:0] CMD_NOP   = 4'b0111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flag_init_end,
  input  logic [2:0]  req_in,
  input  logic [2:0]  done_in,
  output logic [2:0]  grant,
  input  logic [15:0] cmd_bus,
  input  logic [47:0] addr_bus,
  input  logic [3:0]  ba_bus,
  output logic [3:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_bank,
  output logic [4:0]  arb_state,
  output logic        tmo_err
);
  typedef enum logic [4:0] {
    S_INIT  = 5'b00001,
    S_ARBIT = 5'b00010,
    S_AREF  = 5'b00100,
    S_WRITE = 5'b01000,
    S_READ  = 5'b10000
  } state_t;
  state_t state_q, state_d;
  logic [9:0] wdog_q, wdog_d;
  logic tmo_err_q, tmo_err_d;
  logic busy, done, tmo;
  always_comb begin
    grant = {state_q == S_READ, state_q == S_WRITE, state_q == S_AREF};
    busy  = |grant;
    done  = |(done_in & grant);
    tmo   = busy && wdog_q == GRANT_TMO && !done;
    state_d = state_q;
    case (state_q)
      S_INIT:  state_d = flag_init_end ? S_ARBIT : S_INIT;
      S_ARBIT: state_d = req_in[0] ? S_AREF : req_in[1] ? S_WRITE : req_in[2] ? S_READ : S_ARBIT;
      default: state_d = (done || tmo) ? S_ARBIT : state_q;
    endcase
    // Counter only advances while the same unit keeps the bus, so every grant starts at zero.
    wdog_d    = (busy && state_d == state_q) ? wdog_q + 10'd1 : 10'd0;
    tmo_err_d = tmo_err_q | tmo;
    sdram_cmd  = state_q == S_INIT  ? cmd_bus[3:0]    :
                 state_q == S_AREF  ? cmd_bus[7:4]    :
                 state_q == S_WRITE ? cmd_bus[11:8]   :
                 state_q == S_READ  ? cmd_bus[15:12]  : CMD_NOP;
    sdram_addr = state_q == S_INIT  ? addr_bus[11:0]  :
                 state_q == S_AREF  ? addr_bus[23:12] :
                 state_q == S_WRITE ? addr_bus[35:24] :
                 state_q == S_READ  ? addr_bus[47:36] : 12'd0;
    sdram_bank = state_q == S_WRITE ? ba_bus[1:0] :
                 state_q == S_READ  ? ba_bus[3:2] : 2'b00;
    arb_state  = state_q;
    tmo_err    = tmo_err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      wdog_q    <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      tmo_err_q <= tmo_err_d;
    end
  end
endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed self-checking bench for the SDRAM command-bus arbiter.
module tb_sdram_arbit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flag_init_end;
  logic [2:0]  req_in, done_in, grant;
  logic [15:0] cmd_bus;
  logic [47:0] addr_bus;
  logic [3:0]  ba_bus, sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;
  logic [4:0]  arb_state;
  logic        tmo_err;
  int n_vec = 0;
  int n_bad = 0;

  sdram_arbit dut (
    .clk(clk), .rst_n(rst_n), .flag_init_end(flag_init_end),
    .req_in(req_in), .done_in(done_in), .grant(grant),
    .cmd_bus(cmd_bus), .addr_bus(addr_bus), .ba_bus(ba_bus),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
    .arb_state(arb_state), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pins(input string tag, input logic [4:0] st, input logic [2:0] g,
                          input logic [3:0] c, input logic [11:0] a, input logic [1:0] b);
    chk({tag, ".state"}, {11'd0, arb_state}, {11'd0, st});
    chk({tag, ".grant"}, {13'd0, grant}, {13'd0, g});
    chk({tag, ".cmd"}, {12'd0, sdram_cmd}, {12'd0, c});
    chk({tag, ".addr"}, {4'd0, sdram_addr}, {4'd0, a});
    chk({tag, ".bank"}, {14'd0, sdram_bank}, {14'd0, b});
  endtask

  initial begin
    rst_n = 1'b0; flag_init_end = 1'b0; req_in = 3'b000; done_in = 3'b000;
    cmd_bus  = {4'b0101, 4'b0100, 4'b0001, 4'b0010};
    addr_bus = {12'h5A5, 12'h403, 12'h400, 12'h123};
    ba_bus   = {2'b10, 2'b01};
    tick(2);
    chk_pins("reset", 5'b00001, 3'b000, 4'b0010, 12'h123, 2'b00);
    chk("reset.tmo", {15'd0, tmo_err}, 16'd0);
    rst_n = 1'b1;
    tick(200);
    chk_pins("init_hold", 5'b00001, 3'b000, 4'b0010, 12'h123, 2'b00);
    flag_init_end = 1'b1;
    tick(1);
    flag_init_end = 1'b0;
    chk_pins("arbit_nop", 5'b00010, 3'b000, 4'b0111, 12'h000, 2'b00);
    tick(2);
    chk("arbit_idle", {11'd0, arb_state}, 16'h0002);
    // all three request together: AREF first
    req_in = 3'b111;
    tick(1);
    req_in = 3'b110;
    chk_pins("aref_grant", 5'b00100, 3'b001, 4'b0001, 12'h400, 2'b00);
    done_in = 3'b010;
    tick(1);
    chk("aref_ignores_wr_done", {13'd0, grant}, 16'h0001);
    done_in = 3'b001;
    tick(1);
    done_in = 3'b000;
    chk_pins("aref_release", 5'b00010, 3'b000, 4'b0111, 12'h000, 2'b00);
    tick(1);
    req_in = 3'b100;
    chk_pins("write_grant", 5'b01000, 3'b010, 4'b0100, 12'h403, 2'b01);
    // AREF arrives while WRITE owns the bus: no pre-emption
    req_in = 3'b101;
    flag_init_end = 1'b1;
    tick(5);
    flag_init_end = 1'b0;
    chk("write_no_preempt", {13'd0, grant}, 16'h0002);
    done_in = 3'b010;
    tick(1);
    done_in = 3'b000;
    chk("write_release", {11'd0, arb_state}, 16'h0002);
    tick(1);
    req_in = 3'b100;
    chk("aref_beats_rd", {13'd0, grant}, 16'h0001);
    done_in = 3'b001;
    tick(1);
    done_in = 3'b000;
    tick(1);
    req_in = 3'b000;
    chk_pins("read_grant", 5'b10000, 3'b100, 4'b0101, 12'h5A5, 2'b10);
    // watchdog: READ entered with wdog=0, expires after 1024 cycles of ownership
    tick(1023);
    chk("read_before_tmo", {13'd0, grant}, 16'h0004);
    chk("tmo_not_yet", {15'd0, tmo_err}, 16'd0);
    tick(1);
    chk_pins("tmo_release", 5'b00010, 3'b000, 4'b0111, 12'h000, 2'b00);
    chk("tmo_set", {15'd0, tmo_err}, 16'd1);
    tick(3);
    chk("tmo_sticky", {15'd0, tmo_err}, 16'd1);
    req_in = 3'b100;
    tick(1);
    req_in = 3'b000;
    chk("read_regrant", {13'd0, grant}, 16'h0004);
    tick(3);
    rst_n = 1'b0;
    #1;
    chk_pins("async_reset", 5'b00001, 3'b000, 4'b0010, 12'h123, 2'b00);
    chk("async_reset.tmo", {15'd0, tmo_err}, 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
